slr_cross_hs: RTL and testbench

- Valid/ready flow-controlled SLR crossing. It is the return-path counterpart to the data-only slr_cross pipeline.
- The forward path carries valid+data through a registered SLL pipeline. The reverse path carries credit-return pulses back through an equal-length SLL pipeline.
- A receive-side FIFO sized for the round trip absorbs in-flight words, so backpressure crosses the SLR without any combinational ready path.
- Placed wherever a handshaked stream (AXI-Stream-like) spans two SLRs.

---
 rtl/slr_cross_pkg.sv | 25 ++
 rtl/slr_cross_rx_fifo.sv | 63 ++++++
 rtl/slr_cross_hs.sv | 109 ++++++++++
 tb/tb_slr_cross_hs.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/slr_cross_pkg.sv
// Shared helpers for SLR crossing blocks: pipeline latency, depth and width math.
`timescale 1ns/1ps
package slr_cross_pkg;

  // Register stages per direction: extra pre-stages + SLL TX + SLL RX + extra post-stages.
  function automatic int slr_lat(input int regs_before, input int regs_after);
    return regs_before + 2 + regs_after;
  endfunction

  // Smallest receive depth that covers the credit round trip at one word per cycle.
  function automatic int slr_min_depth(input int regs_before, input int regs_after);
    return 2 * slr_lat(regs_before, regs_after) + 2;
  endfunction

  // Credit counter width: must hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // FIFO index bits; pointers carry one extra wrap bit on top of this.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/slr_cross_rx_fifo.sv
// Circular receive buffer with wrap-bit pointers; exposes count/empty/full.
`timescale 1ns/1ps
module slr_cross_rx_fifo
  import slr_cross_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [ptr_w(DEPTH):0]      count
);

  localparam int AW = ptr_w(DEPTH);
  localparam int IW = (AW > 0) ? AW : 1;
  localparam logic [AW:0] DEPTH_P = DEPTH[AW:0];

  logic [AW:0]       wptr, rptr;
  logic [IW-1:0]     waddr, raddr;
  logic [WIDTH-1:0]  mem [DEPTH];

  generate
    if (AW > 0) begin : g_addr
      assign waddr = wptr[AW-1:0];
      assign raddr = rptr[AW-1:0];
    end else begin : g_addr1
      assign waddr = '0;
      assign raddr = '0;
    end
  endgenerate

  assign count   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (count == DEPTH_P);
  assign rd_data = mem[raddr];

  // Storage has no reset so it maps onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + (AW+1)'(1);
      if (rd_en) rptr <= rptr + (AW+1)'(1);
    end
  end

`ifndef SYNTHESIS
  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(wr_en && full && !rd_en));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(rd_en && empty));
`endif

endmodule

// File: rtl/slr_cross_hs.sv
// Credit-based valid/ready SLR crossing: registered forward data path, registered
// credit-return path, and a receive FIFO that absorbs everything in flight.
`timescale 1ns/1ps
module slr_cross_hs
  import slr_cross_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int REGS_BEFORE = 1,
  parameter int REGS_AFTER  = 1,
  parameter int DEPTH       = 16
) (
  input  logic             clk,
  input  logic             sreset,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  localparam int L  = slr_lat(REGS_BEFORE, REGS_AFTER);
  localparam int CW = cnt_w(DEPTH);
  localparam int AW = ptr_w(DEPTH);

  logic [CW-1:0]           credits;
  logic                    send, pop, fifo_empty, fifo_full;
  logic [AW:0]             fifo_count;
  logic [L:0]              vld_pipe;
  logic [L:0][WIDTH-1:0]   dat_pipe;
  logic [L:0]              crd_pipe;

  assign send        = s_valid & s_ready;
  assign pop         = m_valid & m_ready;
  assign vld_pipe[0] = send;
  assign dat_pipe[0] = s_data;
  assign crd_pipe[0] = pop;

  // Stage REGS_BEFORE is the SLL TX register, REGS_BEFORE+1 the SLL RX register.
  generate
    for (genvar i = 0; i < L; i++) begin : g_stage
      if (i == REGS_BEFORE || i == REGS_BEFORE + 1) begin : g_sll
        (* USER_SLL_REG = "yes", shreg_extract = "no" *) logic             v_q;
        (* USER_SLL_REG = "yes", shreg_extract = "no" *) logic [WIDTH-1:0] d_q;
        (* USER_SLL_REG = "yes", shreg_extract = "no" *) logic             c_q;
        always_ff @(posedge clk or posedge sreset) begin
          if (sreset) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
          end else begin
            v_q <= vld_pipe[i];
            c_q <= crd_pipe[i];
          end
        end
        always_ff @(posedge clk) d_q <= dat_pipe[i];
        assign vld_pipe[i+1] = v_q;
        assign dat_pipe[i+1] = d_q;
        assign crd_pipe[i+1] = c_q;
      end else begin : g_reg
        (* shreg_extract = "no" *) logic             v_q;
        (* shreg_extract = "no" *) logic [WIDTH-1:0] d_q;
        (* shreg_extract = "no" *) logic             c_q;
        always_ff @(posedge clk or posedge sreset) begin
          if (sreset) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
          end else begin
            v_q <= vld_pipe[i];
            c_q <= crd_pipe[i];
          end
        end
        always_ff @(posedge clk) d_q <= dat_pipe[i];
        assign vld_pipe[i+1] = v_q;
        assign dat_pipe[i+1] = d_q;
        assign crd_pipe[i+1] = c_q;
      end
    end
  endgenerate

  // Send and return in the same cycle cancel out.
  always_ff @(posedge clk or posedge sreset) begin
    if (sreset)                       credits <= CW'(DEPTH);
    else if (send && !crd_pipe[L])    credits <= credits - CW'(1);
    else if (!send && crd_pipe[L])    credits <= credits + CW'(1);
  end

  assign s_ready = (credits != '0);
  assign m_valid = !fifo_empty;

  slr_cross_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (sreset),
    .wr_en   (vld_pipe[L]),
    .wr_data (dat_pipe[L]),
    .rd_en   (pop),
    .rd_data (m_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

`ifndef SYNTHESIS
  a_credit_range: assert property (@(posedge clk) disable iff (sreset) int'(credits) <= DEPTH);
  a_credit_cover: assert property (@(posedge clk) disable iff (sreset)
                                   int'(credits) + int'(fifo_count) <= DEPTH);
  a_full_no_cred: assert property (@(posedge clk) disable iff (sreset) fifo_full |-> credits == '0);
`endif

endmodule

// File: tb/tb_slr_cross_hs.sv
// Directed bench for slr_cross_hs: default config (L=4, DEPTH=16) plus a DEPTH=4 instance.
`timescale 1ns/1ps
module tb_slr_cross_hs;

  logic        clk = 1'b0;
  logic        sreset = 1'b1;
  logic [15:0] a_s_data = '0, a_m_data, b_s_data = '0, b_m_data;
  logic        a_s_valid = 1'b0, a_s_ready, a_m_valid, a_m_ready = 1'b0;
  logic        b_s_valid = 1'b0, b_s_ready, b_m_valid, b_m_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  slr_cross_hs dut_a (
    .clk(clk), .sreset(sreset),
    .s_data(a_s_data), .s_valid(a_s_valid), .s_ready(a_s_ready),
    .m_data(a_m_data), .m_valid(a_m_valid), .m_ready(a_m_ready)
  );

  slr_cross_hs #(.WIDTH(16), .REGS_BEFORE(1), .REGS_AFTER(1), .DEPTH(4)) dut_b (
    .clk(clk), .sreset(sreset),
    .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(b_m_ready)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        sv;
    logic [15:0] sd;
    logic        mr;
    logic        e_srdy;
    logic        e_mvld;
    logic [15:0] e_mdata;
    int          e_cred;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int accepted, exp_w, rise, tx, rx, first, stall, errs;
    int sent, rcv, cred_err;
    logic [15:0] q[$];
    logic [15:0] w;
    bit seen;
    int extra;

    // ---- reset state and idle ----
    repeat (3) @(negedge clk);
    check("rst_srdy", int'(a_s_ready), 1);
    check("rst_mvld", int'(a_m_valid), 0);
    sreset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("idle_srdy", int'(a_s_ready), 1);
      check("idle_mvld", int'(a_m_valid), 0);
      check("idle_cred", int'(dut_a.credits), 16);
    end

    // ---- single word, table driven: send at edge 1, visible after edge 5, credit back after edge 10 ----
    for (int i = 0; i < 12; i++)
      tbl[i] = '{sv: 1'b0, sd: 16'h0, mr: 1'b1, e_srdy: 1'b1, e_mvld: 1'b0, e_mdata: 16'h0, e_cred: 15};
    tbl[0].sv = 1'b1;  tbl[0].sd = 16'hA5A5; tbl[0].e_cred = 16;
    tbl[5].e_mvld = 1'b1; tbl[5].e_mdata = 16'hA5A5;
    tbl[10].e_cred = 16; tbl[11].e_cred = 16;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("vec%0d_srdy", i), int'(a_s_ready), int'(tbl[i].e_srdy));
      check($sformatf("vec%0d_mvld", i), int'(a_m_valid), int'(tbl[i].e_mvld));
      if (tbl[i].e_mvld) check($sformatf("vec%0d_mdata", i), int'(a_m_data), int'(tbl[i].e_mdata));
      check($sformatf("vec%0d_cred", i), int'(dut_a.credits), tbl[i].e_cred);
      a_s_valid = tbl[i].sv;
      a_s_data  = tbl[i].sd;
      a_m_ready = tbl[i].mr;
    end

    // ---- stall fill: exactly DEPTH words accepted, then drain in order ----
    accepted = 0;
    a_m_ready = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      a_s_valid = 1'b1;
      w = accepted[15:0];
      a_s_data = w;
      if (a_s_ready) accepted++;
    end
    @(negedge clk);
    a_s_valid = 1'b0;
    check("fill_count", accepted, 16);
    check("fill_srdy", int'(a_s_ready), 0);
    check("fill_mvld", int'(a_m_valid), 1);
    a_m_ready = 1'b1;
    exp_w = 0; rise = -1; errs = 0;
    for (int c = 0; c < 25; c++) begin
      if (a_m_valid) begin
        if (int'(a_m_data) != exp_w) errs++;
        exp_w++;
      end
      if (rise < 0 && a_s_ready) rise = c;
      @(negedge clk);
    end
    check("drain_order", errs, 0);
    check("drain_count", exp_w, 16);
    check("drain_srdy_rise", rise, 5);
    check("drain_cred", int'(dut_a.credits), 16);

    // ---- full-rate streaming ----
    tx = 0; rx = 0; first = -1; stall = 0; errs = 0;
    for (int c = 0; c < 1100 && rx < 1000; c++) begin
      @(negedge clk);
      if (a_m_valid) begin
        if (int'(a_m_data) != (rx & 16'hFFFF)) errs++;
        if (first < 0) first = c;
        rx++;
      end
      if (tx < 1000) begin
        a_s_valid = 1'b1;
        w = tx[15:0];
        a_s_data = w;
        if (!a_s_ready) stall++;
        else tx++;
      end else a_s_valid = 1'b0;
    end
    a_s_valid = 1'b0;
    check("stream_tx", tx, 1000);
    check("stream_rx", rx, 1000);
    check("stream_stall", stall, 0);
    check("stream_first", first, 5);
    check("stream_order", errs, 0);

    // ---- DEPTH=4, random flow control, scoreboard ----
    sent = 0; rcv = 0; errs = 0; cred_err = 0;
    for (int c = 0; c < 640; c++) begin
      @(negedge clk);
      if (c < 600) begin
        b_s_valid = ($urandom_range(0, 9) < 7);
        b_s_data  = 16'($urandom);
        b_m_ready = ($urandom_range(0, 1) == 1);
      end else begin
        b_s_valid = 1'b0;
        b_m_ready = 1'b1;
      end
      if (b_s_valid && b_s_ready) begin
        q.push_back(b_s_data);
        sent++;
      end
      if (b_m_valid && b_m_ready) begin
        if (q.size() == 0) errs++;
        else begin
          w = q.pop_front();
          if (b_m_data !== w) errs++;
        end
        rcv++;
      end
      if (int'(dut_b.credits) > 4) cred_err++;
    end
    check("rand_order", errs, 0);
    check("rand_cred_range", cred_err, 0);
    check("rand_left", q.size(), 0);
    check("rand_count", rcv, sent);
    check("rand_cred_end", int'(dut_b.credits), 4);

    // ---- mid-stream reset ----
    a_m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a_s_valid = 1'b1;
      a_s_data  = 16'h0100 + 16'(i);
    end
    @(negedge clk);
    a_s_valid = 1'b0;
    check("pre_rst_mvld", int'(a_m_valid), 1);
    sreset = 1'b1;
    #1;
    check("mid_rst_mvld", int'(a_m_valid), 0);
    check("mid_rst_srdy", int'(a_s_ready), 1);
    repeat (2) @(negedge clk);
    sreset = 1'b0;
    @(negedge clk);
    check("post_rst_cred", int'(dut_a.credits), 16);
    check("post_rst_mvld", int'(a_m_valid), 0);
    a_s_valid = 1'b1;
    a_s_data  = 16'h1234;
    a_m_ready = 1'b1;
    @(negedge clk);
    a_s_valid = 1'b0;
    seen = 1'b0; extra = 0;
    for (int c = 0; c < 30; c++) begin
      if (a_m_valid) begin
        if (!seen) begin
          check("post_rst_first", int'(a_m_data), 16'h1234);
          seen = 1'b1;
        end else extra++;
      end
      @(negedge clk);
    end
    check("post_rst_seen", int'(seen), 1);
    check("post_rst_extra", extra, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
